// File: rtl/bug_ctl.sv
// ----------------------------------------------------------------------------
// bug_ctl
// Bug position/orientation controller for the sprite drawing stage. The four
// direction keys are sampled once every FRAME_DIV frames, at the start of
// vertical blanking. On each of those samples the bug moves by STEP pixels and
// is clamped inside the visible area. Position and rotation are registered, so
// they stay stable for a whole frame.
//
// Ports
//   pclk       in   pixel clock; all logic runs on the rising edge
//   reset      in   synchronous, active-high reset
//   vblnk_in   in   vertical blanking from the timing chain
//   start      in   pulse: reload the start position and enter RUN
//   stop       in   pulse: freeze the bug and enter IDLE (wins over start)
//   key_up     in   level, move up    (highest priority)
//   key_down   in   level, move down
//   key_left   in   level, move left
//   key_right  in   level, move right (lowest priority)
//   x_bugpos   out  sprite left edge
//   y_bugpos   out  sprite top edge
//   rotation   out  00 up, 01 right, 10 down, 11 left
//   moving     out  high while in RUN and a key was held at the last move event
//   wall_hit   out  one-cycle pulse when a move was clamped at an edge
// ----------------------------------------------------------------------------
module bug_ctl #(
    parameter int SCREEN_W  = 800,
    parameter int SCREEN_H  = 600,
    parameter int BUG_W     = 53,
    parameter int BUG_H     = 54,
    parameter int STEP      = 2,
    parameter int FRAME_DIV = 2,
    parameter int X_START   = 373,
    parameter int Y_START   = 273
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        vblnk_in,
    input  logic        start,
    input  logic        stop,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_left,
    input  logic        key_right,
    output logic [11:0] x_bugpos,
    output logic [11:0] y_bugpos,
    output logic [1:0]  rotation,
    output logic        moving,
    output logic        wall_hit
);

    typedef enum logic {StIdle, StRun} state_t;

    localparam logic signed [12:0] X_MAX    = 13'(SCREEN_W - BUG_W);
    localparam logic signed [12:0] Y_MAX    = 13'(SCREEN_H - BUG_H);
    localparam logic signed [12:0] STEP_S   = 13'(STEP);
    localparam logic [11:0]        X_INIT   = 12'(X_START);
    localparam logic [11:0]        Y_INIT   = 12'(Y_START);
    localparam logic [3:0]         DIV_LAST = 4'(FRAME_DIV - 1);

    localparam logic [1:0] RotUp    = 2'b00;
    localparam logic [1:0] RotRight = 2'b01;
    localparam logic [1:0] RotDown  = 2'b10;
    localparam logic [1:0] RotLeft  = 2'b11;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [11:0] r_x, w_x_nxt;
    logic [11:0] r_y, w_y_nxt;
    logic [1:0]  r_rot, w_rot_nxt;
    logic        r_moving, w_moving_nxt;
    logic        r_wall, w_wall_nxt;
    logic        r_vblnk_d;

    logic               w_frame_tick;
    logic               w_key_any;
    logic signed [12:0] w_dx, w_dy;
    logic signed [12:0] w_x_raw, w_y_raw;
    logic [11:0]        w_x_clamp, w_y_clamp;
    logic               w_clamped;
    logic [1:0]         w_key_rot;

    // Rising edge of vblnk only, so a held-high vblnk gives one tick.
    assign w_frame_tick = vblnk_in & ~r_vblnk_d;
    assign w_key_any    = key_up | key_down | key_left | key_right;

    // Step and rotation for the highest-priority held key.
    always_comb begin
        w_dx      = '0;
        w_dy      = '0;
        w_key_rot = r_rot;
        if (key_up) begin
            w_dy      = -STEP_S;
            w_key_rot = RotUp;
        end else if (key_down) begin
            w_dy      = STEP_S;
            w_key_rot = RotDown;
        end else if (key_left) begin
            w_dx      = -STEP_S;
            w_key_rot = RotLeft;
        end else if (key_right) begin
            w_dx      = STEP_S;
            w_key_rot = RotRight;
        end
    end

    // Signed 13-bit candidate position, clamped to the visible area.
    always_comb begin
        w_x_raw   = $signed({1'b0, r_x}) + w_dx;
        w_y_raw   = $signed({1'b0, r_y}) + w_dy;
        w_clamped = 1'b0;
        w_x_clamp = w_x_raw[11:0];
        w_y_clamp = w_y_raw[11:0];
        if (w_x_raw < $signed(13'd0)) begin
            w_x_clamp = '0;
            w_clamped = 1'b1;
        end else if (w_x_raw > X_MAX) begin
            w_x_clamp = X_MAX[11:0];
            w_clamped = 1'b1;
        end
        if (w_y_raw < $signed(13'd0)) begin
            w_y_clamp = '0;
            w_clamped = 1'b1;
        end else if (w_y_raw > Y_MAX) begin
            w_y_clamp = Y_MAX[11:0];
            w_clamped = 1'b1;
        end
    end

    // Next-state logic: stop beats start, start beats a frame tick.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_rot_nxt    = r_rot;
        w_moving_nxt = r_moving;
        w_wall_nxt   = 1'b0;

        case (r_state)
            StIdle: begin
                w_moving_nxt = 1'b0;
                if (!stop && start) begin
                    w_state_nxt = StRun;
                    w_cnt_nxt   = '0;
                    w_x_nxt     = X_INIT;
                    w_y_nxt     = Y_INIT;
                    w_rot_nxt   = RotUp;
                end
            end
            StRun: begin
                if (stop) begin
                    w_state_nxt  = StIdle;
                    w_moving_nxt = 1'b0;
                end else if (start) begin
                    w_cnt_nxt    = '0;
                    w_x_nxt      = X_INIT;
                    w_y_nxt      = Y_INIT;
                    w_rot_nxt    = RotUp;
                    w_moving_nxt = 1'b0;
                end else if (w_frame_tick) begin
                    if (r_cnt == DIV_LAST) begin
                        w_cnt_nxt    = '0;
                        w_moving_nxt = w_key_any;
                        if (w_key_any) begin
                            w_x_nxt    = w_x_clamp;
                            w_y_nxt    = w_y_clamp;
                            w_rot_nxt  = w_key_rot;
                            w_wall_nxt = w_clamped;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_x       <= X_INIT;
            r_y       <= Y_INIT;
            r_rot     <= RotUp;
            r_moving  <= 1'b0;
            r_wall    <= 1'b0;
            r_vblnk_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_rot     <= w_rot_nxt;
            r_moving  <= w_moving_nxt;
            r_wall    <= w_wall_nxt;
            r_vblnk_d <= vblnk_in;
        end
    end

    assign x_bugpos = r_x;
    assign y_bugpos = r_y;
    assign rotation = r_rot;
    assign moving   = r_moving;
    assign wall_hit = r_wall;

endmodule
